// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux through its enabled channels and packs the samples.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] ch_mask,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] q
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("mux_scan_sequencer: SETTLE=%0d outside 1..15", SETTLE);
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] q_q, q_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] higher;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest = 2'(i);
    end
  endfunction

  // Enabled channels strictly above the one currently selected.
  always_comb begin
    higher = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      higher[i] = mask_q[i] && (i > int'(idx_q));
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = 2'd0;
        if (start) begin
          mask_d = ch_mask;
          if (ch_mask == 4'b0000) begin
            done_d = 1'b1;
            q_d    = 4'b0000;
          end else begin
            idx_d    = lowest(ch_mask);
            cnt_d    = CNT_LOAD;
            busy_d   = 1'b1;
            shadow_d = 4'b0000;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_SAMPLE: begin
        shadow_d[idx_q] = y;
        if (higher != 4'b0000) begin
          idx_d   = lowest(higher);
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end else begin
          // q must include the sample taken on this very edge.
          q_d    = shadow_d;
          done_d = 1'b1;
          if (cont && ch_mask != 4'b0000) begin
            mask_d   = ch_mask;
            idx_d    = lowest(ch_mask);
            cnt_d    = CNT_LOAD;
            shadow_d = 4'b0000;
            state_d  = ST_SETTLE;
          end else begin
            if (cont) mask_d = ch_mask;
            idx_d   = 2'd0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= 4'd0;
      mask_q   <= 4'd0;
      shadow_q <= 4'd0;
      q_q      <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign s0   = idx_q[0];
  assign s1   = idx_q[1];
  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream and downstream controller for the team's 4:1 gate-level mux (inputs a,b,c,d; selects s1,s0; output y).
- Steps the mux select lines through channels 0..3 (a,b,c,d), waits a settle time on each, samples y, and packs the four samples into a 4-bit word with a done pulse.
- Supports channel masking and continuous scanning.
- Sits between the mux instance and whatever register or bus consumes the scanned word.

Parameters:
- SETTLE, 1, number of cycles selects are held on a channel before its sample cycle; legal range 1..15; 4-bit counter.

Ports:
- clk      input   1  rising-edge clock
- rst      input   1  synchronous, active-high reset
- start    input   1  begin a scan; sampled only in IDLE
- cont     input   1  continuous mode; sampled at end of each scan
- ch_mask  input   4  channel enable, bit i = channel i; latched on accepted start
- y        input   1  mux output
- s0       output  1  mux select LSB = idx[0]
- s1       output  1  mux select MSB = idx[1]
- busy     output  1  high from the cycle after an accepted start until the scan ends
- done     output  1  one-cycle pulse, high in the cycle after the last sample edge
- q        output  4  scanned word; q[i] = sample of channel i; 0 for masked channels

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst. Everything updates on the rising edge of clk.
- Reset values: state=IDLE, idx=0 (s1=0, s0=0), busy=0, done=0, q=0, shadow=0, cnt=0, mask_r=0. Reset mid-scan aborts immediately; no done pulse; q is cleared.
- Selects: s1,s0 come combinationally from the idx register only, so they are glitch-free relative to clk. idx=0 in IDLE.
- States: IDLE, SETTLE, SAMPLE.
- IDLE with start=1:
  - latch mask_r=ch_mask; idx = lowest enabled channel; cnt=SETTLE-1; busy=1; shadow=0; go to SETTLE.
  - If ch_mask=0000: stay IDLE, busy stays 0, done=1 next cycle, q=0000.
- SETTLE: hold idx. Decrement cnt each cycle; when cnt=0, go to SAMPLE. Dwell is exactly SETTLE cycles.
- SAMPLE (1 cycle): shadow[idx] <= y at the closing edge.
  - If a higher enabled channel exists: idx <= next enabled channel, cnt=SETTLE-1, go to SETTLE.
  - Otherwise (last sample): q <= shadow with bit idx = y; done <= 1 for one cycle.
    - cont=1: re-latch mask_r=ch_mask, idx=lowest enabled, go to SETTLE, busy stays 1. If the new mask is 0000, go to IDLE with busy=0.
    - cont=0: go to IDLE, idx=0, busy<=0.
- Per-channel cost is SETTLE+1 cycles; masked channels cost 0 cycles.
- Latency: with N enabled channels, done is high in the cycle after edge E0 + N*(SETTLE+1), where E0 is the accepting start edge.
- Boundary cases:
  - start while busy: ignored.
  - start during the done cycle of a cont=0 scan: accepted, since the state is IDLE.
  - ch_mask changes mid-scan: no effect until the next latch.
  - cont deasserted mid-scan: the current scan completes, then IDLE.
  - q holds its value between scans and updates only on the last-sample edge.
  - done and start never interact with q in the same cycle except as described above.
- SETTLE outside 1..15 is illegal. The implementation flags it with a simulation-time error at elaboration.

Test Plan:
1. SETTLE=1, mux a=1,b=0,c=1,d=1, ch_mask=1111, cont=0, start pulse at E0.
   - Required: s1s0 = 00,00,01,01,10,10,11,11 over cycles 1-8; done high in cycle 9 only; q=1101; busy falls with done; idle s1s0=00.
2. Same inputs, ch_mask=1010.
   - Required: only idx 1 and 3 are visited; done in cycle 5; q=1000.
3. ch_mask=0000, start.
   - Required: busy stays 0; done in cycle 1; q=0000.
4. cont=1, ch_mask=1111, a..d=0101 (a=1,c=1) for scan 1, then d flipped to 1.
   - Required: done every 8 cycles with no gap; q=0101, then 1101.
   - Clear cont mid-scan 3: scan 3 completes, then IDLE.
5. rst=1 during SAMPLE of channel 2 (mid-scan).
   - Required next cycle: busy=0, done=0, q=0000, s1s0=00.
   - start reasserted while busy in a fresh scan: no restart; done count unchanged.
6. SETTLE=3, ch_mask=1111.
   - Required: each select value is held 4 cycles; done in cycle 17.
   - start held high continuously with cont=0: back-to-back scans, start accepted in each done cycle.
